// File: rtl/decode_stage_if.sv
`default_nettype none
// decode_stage_if: handshake and decoded-payload bundle between fetch, decode and execute.
// Revision 1.0
interface decode_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       rd;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [XLEN-1:0]  imm;
   logic [2:0]       ImmSel;
   logic             Op2Sel;
   logic             RegWrite;
   logic             illegal;
   logic [CNT_W-1:0] decode_count;
   logic [CNT_W-1:0] illegal_count;

   modport slave (
      input  in_valid, instr, flush, out_ready,
      output in_ready, out_valid, rd, funct3, funct7, rs1, rs2, imm,
             ImmSel, Op2Sel, RegWrite, illegal, decode_count, illegal_count
   );

   modport master (
      output in_valid, instr, flush, out_ready,
      input  in_ready, out_valid, rd, funct3, funct7, rs1, rs2, imm,
             ImmSel, Op2Sel, RegWrite, illegal, decode_count, illegal_count
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// decode_stage: registered RV32I decoder with one-entry valid/ready output, flush and saturating counters.
// Revision 1.0
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  wire logic     clk,
   input  wire logic     reset,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [2:0] IMM_I    = 3'd0;
   localparam logic [2:0] IMM_S    = 3'd1;
   localparam logic [2:0] IMM_B    = 3'd2;
   localparam logic [2:0] IMM_U    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_NONE = 3'd7;

   logic [31:0]     ins;
   logic [4:0]      d_rd;
   logic [4:0]      d_rs1;
   logic [4:0]      d_rs2;
   logic [2:0]      d_funct3;
   logic [6:0]      d_funct7;
   logic [2:0]      d_imm_sel;
   logic [XLEN-1:0] d_imm;
   logic            d_op2_sel;
   logic            d_reg_write;
   logic            d_illegal;
   logic            in_ready;
   logic            accept;

   assign ins          = bus.instr;
   assign in_ready     = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid && in_ready;

   always_comb begin
      d_rd        = 5'd0;
      d_rs1       = 5'd0;
      d_rs2       = 5'd0;
      d_funct3    = ins[14:12];
      d_funct7    = 7'd0;
      d_imm_sel   = IMM_NONE;
      d_op2_sel   = 1'b1;
      d_reg_write = 1'b0;
      d_illegal   = 1'b0;
      case (ins[6:0])
         OP_R: begin
            d_rs1       = ins[19:15];
            d_rs2       = ins[24:20];
            d_rd        = ins[11:7];
            d_funct7    = ins[31:25];
            d_reg_write = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            d_rs1       = ins[19:15];
            d_rd        = ins[11:7];
            d_imm_sel   = IMM_I;
            d_op2_sel   = 1'b0;
            d_reg_write = 1'b1;
         end
         OP_STORE: begin
            d_rs1     = ins[19:15];
            d_rs2     = ins[24:20];
            d_imm_sel = IMM_S;
            d_op2_sel = 1'b0;
         end
         OP_BRANCH: begin
            d_rs1     = ins[19:15];
            d_rs2     = ins[24:20];
            d_imm_sel = IMM_B;
         end
         OP_LUI, OP_AUIPC: begin
            d_rd        = ins[11:7];
            d_imm_sel   = IMM_U;
            d_op2_sel   = 1'b0;
            d_reg_write = 1'b1;
         end
         OP_JAL: begin
            d_rd        = ins[11:7];
            d_imm_sel   = IMM_J;
            d_op2_sel   = 1'b0;
            d_reg_write = 1'b1;
         end
         default: begin
            d_illegal = 1'b1;
            d_funct3  = 3'd0;
         end
      endcase

      // Immediate follows the selected format; R-type and illegal leave it zero.
      case (d_imm_sel)
         IMM_I:   d_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
         IMM_S:   d_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   d_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   d_imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'd0};
         IMM_J:   d_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: d_imm = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid     <= 1'b0;
         bus.rd            <= 5'd0;
         bus.rs1           <= 5'd0;
         bus.rs2           <= 5'd0;
         bus.funct3        <= 3'd0;
         bus.funct7        <= 7'd0;
         bus.imm           <= '0;
         bus.ImmSel        <= IMM_NONE;
         bus.Op2Sel        <= 1'b1;
         bus.RegWrite      <= 1'b0;
         bus.illegal       <= 1'b0;
         bus.decode_count  <= '0;
         bus.illegal_count <= '0;
      end else if (bus.flush) begin
         // A same-cycle accept is discarded along with the held payload.
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.rd        <= d_rd;
         bus.rs1       <= d_rs1;
         bus.rs2       <= d_rs2;
         bus.funct3    <= d_funct3;
         bus.funct7    <= d_funct7;
         bus.imm       <= d_imm;
         bus.ImmSel    <= d_imm_sel;
         bus.Op2Sel    <= d_op2_sel;
         bus.RegWrite  <= d_reg_write;
         bus.illegal   <= d_illegal;
         if (bus.decode_count != '1) begin
            bus.decode_count <= bus.decode_count + 1'b1;
         end
         if (d_illegal && (bus.illegal_count != '1)) begin
            bus.illegal_count <= bus.illegal_count + 1'b1;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// tb_decode_stage: directed checks of decode, handshake, flush, reset and counter saturation.
// Revision 1.0
module tb_decode_stage;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   decode_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
   decode_stage_if #(.XLEN(32), .CNT_W(2))  sbus ();

   decode_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   decode_stage #(.XLEN(32), .CNT_W(2)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.in_valid  = 1'b0;
      bus.instr     = 32'd0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      sbus.in_valid  = 1'b0;
      sbus.instr     = 32'hFFFF_FFFF;
      sbus.flush     = 1'b0;
      sbus.out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_immsel", 32'(bus.ImmSel), 32'd7);
      check("rst_op2sel", 32'(bus.Op2Sel), 32'd1);
      check("rst_imm", bus.imm, 32'd0);
      check("rst_dcount", 32'(bus.decode_count), 32'd0);
      check("rst_icount", 32'(bus.illegal_count), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // addi x1,x0,5
      bus.in_valid = 1'b1;
      bus.instr    = 32'h0050_0093;
      tick();
      check("addi_valid", 32'(bus.out_valid), 32'd1);
      check("addi_rd", 32'(bus.rd), 32'd1);
      check("addi_rs1", 32'(bus.rs1), 32'd0);
      check("addi_imm", bus.imm, 32'h0000_0005);
      check("addi_immsel", 32'(bus.ImmSel), 32'd0);
      check("addi_op2sel", 32'(bus.Op2Sel), 32'd0);
      check("addi_regwrite", 32'(bus.RegWrite), 32'd1);
      check("addi_dcount", 32'(bus.decode_count), 32'd1);

      // sw x2,8(x1) then beq x0,x0,-4 back to back
      bus.instr = 32'h0020_A423;
      tick();
      check("sw_valid", 32'(bus.out_valid), 32'd1);
      check("sw_rs1", 32'(bus.rs1), 32'd1);
      check("sw_rs2", 32'(bus.rs2), 32'd2);
      check("sw_rd", 32'(bus.rd), 32'd0);
      check("sw_funct3", 32'(bus.funct3), 32'd2);
      check("sw_imm", bus.imm, 32'h0000_0008);
      check("sw_immsel", 32'(bus.ImmSel), 32'd1);
      check("sw_regwrite", 32'(bus.RegWrite), 32'd0);
      bus.instr = 32'hFE00_0EE3;
      tick();
      check("beq_valid", 32'(bus.out_valid), 32'd1);
      check("beq_imm", bus.imm, 32'hFFFF_FFFC);
      check("beq_immsel", 32'(bus.ImmSel), 32'd2);
      check("beq_op2sel", 32'(bus.Op2Sel), 32'd1);
      check("beq_regwrite", 32'(bus.RegWrite), 32'd0);

      // sub x3,x1,x2
      bus.instr = 32'h4020_81B3;
      tick();
      check("sub_funct7", 32'(bus.funct7), 32'h20);
      check("sub_rs1", 32'(bus.rs1), 32'd1);
      check("sub_rs2", 32'(bus.rs2), 32'd2);
      check("sub_rd", 32'(bus.rd), 32'd3);
      check("sub_immsel", 32'(bus.ImmSel), 32'd7);
      check("sub_imm", bus.imm, 32'd0);
      check("sub_op2sel", 32'(bus.Op2Sel), 32'd1);
      check("sub_regwrite", 32'(bus.RegWrite), 32'd1);

      // lui x5,0x12345 ; jal x1,+2048
      bus.instr = 32'h1234_52B7;
      tick();
      check("lui_imm", bus.imm, 32'h1234_5000);
      check("lui_immsel", 32'(bus.ImmSel), 32'd3);
      check("lui_rd", 32'(bus.rd), 32'd5);
      check("lui_rs1", 32'(bus.rs1), 32'd0);
      bus.instr = 32'h0010_00EF;
      tick();
      check("jal_imm", bus.imm, 32'h0000_0800);
      check("jal_immsel", 32'(bus.ImmSel), 32'd4);
      check("jal_rd", 32'(bus.rd), 32'd1);
      check("jal_regwrite", 32'(bus.RegWrite), 32'd1);

      // illegal opcode
      bus.instr = 32'hFFFF_FFFF;
      tick();
      check("ill_flag", 32'(bus.illegal), 32'd1);
      check("ill_regwrite", 32'(bus.RegWrite), 32'd0);
      check("ill_imm", bus.imm, 32'd0);
      check("ill_rd", 32'(bus.rd), 32'd0);
      check("ill_funct3", 32'(bus.funct3), 32'd0);
      check("ill_immsel", 32'(bus.ImmSel), 32'd7);
      check("ill_icount", 32'(bus.illegal_count), 32'd1);
      check("ill_dcount", 32'(bus.decode_count), 32'd7);

      // stall with a new instruction waiting
      bus.out_ready = 1'b0;
      bus.instr     = 32'h0050_0093;
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_illegal", 32'(bus.illegal), 32'd1);
         check("stall_dcount", 32'(bus.decode_count), 32'd7);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("xfer_acc_valid", 32'(bus.out_valid), 32'd1);
      check("xfer_acc_illegal", 32'(bus.illegal), 32'd0);
      check("xfer_acc_rd", 32'(bus.rd), 32'd1);
      check("xfer_acc_dcount", 32'(bus.decode_count), 32'd8);

      // flush coincident with an accept
      bus.instr = 32'h1234_52B7;
      bus.flush = 1'b1;
      #1;
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.flush = 1'b0;
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      check("flush_dcount", 32'(bus.decode_count), 32'd8);
      check("flush_icount", 32'(bus.illegal_count), 32'd1);

      // transfer without accept drains the register
      bus.instr = 32'h0010_00EF;
      tick();
      check("refill_valid", 32'(bus.out_valid), 32'd1);
      check("refill_dcount", 32'(bus.decode_count), 32'd9);
      bus.in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      // reset during a stall
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      check("prerst_valid", 32'(bus.out_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_dcount", 32'(bus.decode_count), 32'd0);
      check("midrst_icount", 32'(bus.illegal_count), 32'd0);
      check("midrst_rd", 32'(bus.rd), 32'd0);
      check("midrst_immsel", 32'(bus.ImmSel), 32'd7);
      bus.out_ready = 1'b1;

      // narrow counters saturate at 3
      sbus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      sbus.in_valid = 1'b0;
      tick();
      check("sat_dcount", 32'(sbus.decode_count), 32'd3);
      check("sat_icount", 32'(sbus.illegal_count), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction decode stage; successor to the combinational control decoder.
- Sits between instruction fetch and register-file read / execute.
- Decodes all base RV32I formats (R, I, S, B, U, J) and builds the sign-extended immediate at XLEN width.
- Uses a valid/ready handshake with one output register, supports flush, flags illegal opcodes, and keeps saturating decode/illegal counters.

Parameters:
XLEN, 32, datapath width; immediate sign-extended to XLEN (XLEN >= 32)
CNT_W, 16, width of decode_count and illegal_count

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  instr is valid this cycle
in_ready  output  1  stage accepts instr this cycle
instr  input  32  instruction word
flush  input  1  discard held output (branch redirect)
out_valid  output  1  decoded payload valid
out_ready  input  1  downstream accepts payload
rd  output  5  destination register
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25] (R type only, else 0)
rs1  output  5  source register 1
rs2  output  5  source register 2
imm  output  XLEN  sign-extended immediate
ImmSel  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 7=none
Op2Sel  output  1  0=imm, 1=reg
RegWrite  output  1  writes rd
illegal  output  1  opcode not recognised
decode_count  output  CNT_W  accepted instructions, saturating
illegal_count  output  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset: out_valid=0, every payload output=0, ImmSel=7, Op2Sel=1, both counters=0.
- Reset has priority over flush and capture.
- in_ready = !out_valid || out_ready. Combinational; no dependency on in_valid.
- Accept: in_valid && in_ready. On an accept edge, decoded payload is registered and out_valid=1.
- Latency: exactly 1 cycle from accept to out_valid.
- Transfer: out_valid && out_ready. If transfer occurs and there is no accept, out_valid goes to 0 the next cycle.
- Transfer and accept in the same cycle: new payload replaces old and out_valid stays 1, giving back-to-back throughput.
- Stall: out_valid && !out_ready leaves the payload and out_valid frozen.
- Flush: next cycle out_valid=0. A same-cycle accept is dropped and is not counted. in_ready is unchanged by flush.
- Decode by opcode instr[6:0]:
  - 0x33 R: rs1, rs2, rd, funct7; ImmSel=7, imm=0, Op2Sel=1, RegWrite=1.
  - 0x13 ALU-I, 0x03 LOAD, 0x67 JALR: rs1, rd; rs2=0; ImmSel=0; Op2Sel=0; RegWrite=1.
  - 0x23 S: rs1, rs2; rd=0; ImmSel=1; Op2Sel=0; RegWrite=0.
  - 0x63 B: rs1, rs2; rd=0; ImmSel=2; Op2Sel=1; RegWrite=0.
  - 0x37 LUI, 0x17 AUIPC: rd; rs1=rs2=0; ImmSel=3; Op2Sel=0; RegWrite=1.
  - 0x6F JAL: rd; rs1=rs2=0; ImmSel=4; Op2Sel=0; RegWrite=1.
  - Any other opcode: illegal=1; rd=rs1=rs2=0, funct3=0, funct7=0, imm=0, ImmSel=7, Op2Sel=1, RegWrite=0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- rd=x0 still sets RegWrite per format; no suppression in this stage.
- Counters increment on accept that is not flushed; illegal_count increments only when the accepted instr is illegal.
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with in_valid=1, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0x00000005, ImmSel=0, Op2Sel=0, RegWrite=1, decode_count=1.
- sw x2,8(x1) (0x0020A423) then beq x0,x0,-4 (0xFE000EE3) back-to-back -> S: rs1=1, rs2=2, imm=8, ImmSel=1, RegWrite=0; B: imm=0xFFFFFFFC, ImmSel=2, Op2Sel=1; out_valid high on 2 consecutive cycles.
- lui x5,0x12345 (0x123452B7); jal x1,+2048 (0x001000EF) -> imm=0x12345000 ImmSel=3; imm=0x00000800 ImmSel=4 rd=1.
- instr=0xFFFFFFFF -> illegal=1, RegWrite=0, imm=0, illegal_count=1.
- out_ready=0 with out_valid=1 for 3 cycles, in_valid=1 -> in_ready=0, payload stable, decode_count unchanged; out_ready=1 -> transfer and accept in the same cycle.
- Flush asserted in the same cycle as an accept -> out_valid=0 next cycle, counters unchanged. Reset asserted mid-stall -> out_valid=0 and counters=0 next cycle. CNT_W=2 with 5 accepts -> decode_count stays 3.
